register_bank: RTL and testbench
================================

// Module: register_bank
// PURPOSE
//  ARM register file; receives the WriteBack stage's 32-bit Result on write port 3.
//  Two combinational operand read ports serve decode/execute:
//  - RD1: Rn
//  - RD2: Rm, or Rd for STR
//  R15 reads return the externally supplied PC+8 value.
//  A registered debug read port feeds the calculator display.
// PARAMETERS
//  DATA_W   32  register/data width
//  ADDR_W   4   register address width (R0..R15)
//  BYPASS   1   1: same-cycle write-to-read forwarding on RD1/RD2; 0: old value returned
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       asynchronous active-low reset
//  WE3      in   1       write enable from WriteBack (RegWrite)
//  A3       in   ADDR_W  write address
//  WD3      in   DATA_W  write data (WriteBack Result)
//  A1       in   ADDR_W  read address, port 1
//  A2       in   ADDR_W  read address, port 2
//  R15      in   DATA_W  PC+8 value returned for reads of register 15
//  RD1      out  DATA_W  read data, port 1 (combinational)
//  RD2      out  DATA_W  read data, port 2 (combinational)
//  DbgAddr  in   ADDR_W  debug read address
//  DbgData  out  DATA_W  debug read data (registered, 1-cycle latency)
// BEHAVIOUR
//  Storage
//  - 15 physical registers, R0..R14.
//  - No storage exists for R15.
//  Reset
//  - rst_n=0 asynchronously clears R0..R14 and DbgData to 0.
//  - Reset overrides any write in the same cycle.
//  - While reset is held, RD1/RD2 show 0 for R0..R14 and R15 for address 15.
//  Write
//  - On posedge clk with rst_n=1 and WE3=1, register[A3] <= WD3.
//  - A3=15: write ignored; PC update is owned by the fetch logic.
//  - WE3=0: no register changes.
//  Read (combinational, zero latency)
//  - RDn = R15 input when An=15, else register[An].
//  - BYPASS=1 and WE3=1 and A3=An and A3!=15: RDn=WD3 (write-through).
//  - BYPASS=0: RDn returns the pre-edge contents; the new value is visible after the edge.
//  - A1=A2 is legal; both ports return identical data.
//  Debug port
//  - Posedge: DbgData <= value at DbgAddr, sampled pre-edge.
//  - DbgAddr=15 samples the R15 input.
//  - Not bypassed: a write to DbgAddr shows on DbgData one cycle after the edge that commits it.
//  Arithmetic/width
//  - No arithmetic; pure storage.
//  - All addresses fully decoded; no X on outputs for any address value.
// TESTING
//  1. Reset: drive rst_n=0 mid-cycle after writes -> RD1/RD2/DbgData = 0 immediately, before any clk edge.
//  2. Write/read: WE3=1,A3=3,WD3=0xDEADBEEF, then WE3=0,A1=3 -> RD1=0xDEADBEEF;
//     A2=4 -> 0x00000000.
//  3. R15: R15=0x00000108,A1=15,A2=15 -> RD1=RD2=0x108;
//     WE3=1,A3=15,WD3=0x55 -> no register changes; A1=15 still 0x108.
//  4. Bypass: BYPASS=1, R5=0x11, same cycle WE3=1,A3=5,WD3=0x22,A1=5 -> RD1=0x22 before the edge;
//     BYPASS=0 -> RD1=0x11 before the edge, 0x22 after.
//  5. Debug latency: DbgAddr=7 with R7=0xA5A5A5A5 -> DbgData=0xA5A5A5A5 one clk after DbgAddr is applied;
//     write R7=0x1 at edge N -> DbgData=0x1 at edge N+1.
//  6. Sweep: write k*0x01010101 to R0..R14 -> read back all via A1, A2 and DbgAddr; no aliasing.

Source files
------------

// File: rtl/register_bank.sv
// ARM register file: R0..R14 storage, R15 supplied externally as PC+8.
// Two combinational read ports, one write port, one registered debug port.
module register_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [DATA_W-1:0] R15,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int NREG  = 15;
  localparam int NVIEW = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(15);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_file [NVIEW];
  logic              w_fwd1;
  logic              w_fwd2;

  // Address view: storage, then PC+8 at 15, zero beyond
  for (genvar g = 0; g < NVIEW; g++) begin : g_view
    if (g < NREG) begin : g_reg
      assign w_file[g] = r_regs[g];
    end else if (g == NREG) begin : g_pc
      assign w_file[g] = R15;
    end else begin : g_none
      assign w_file[g] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (WE3 && A3 == ADDR_W'(i)) r_regs[i] <= WD3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) DbgData <= '0;
    else        DbgData <= w_file[DbgAddr];
  end

  assign w_fwd1 = BYPASS && rst_n && WE3 &&
                  (A3 == A1) && (A3 != PC_A);
  assign w_fwd2 = BYPASS && rst_n && WE3 &&
                  (A3 == A2) && (A3 != PC_A);

  always_comb begin
    RD1 = w_file[A1];
    if (w_fwd1) RD1 = WD3;
  end

  always_comb begin
    RD2 = w_file[A2];
    if (w_fwd2) RD2 = WD3;
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank, bypass and
// non-bypass instances driven in parallel.
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic [31:0] R15;
  logic [3:0]  DbgAddr;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;

  int checks;
  int failures;

  register_bank #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .R15(R15), .RD1(rd1_b), .RD2(rd2_b),
    .DbgAddr(DbgAddr), .DbgData(dbg_b)
  );

  register_bank #(.DATA_W(32), .ADDR_W(4), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .R15(R15), .RD1(rd1_n), .RD2(rd2_n),
    .DbgAddr(DbgAddr), .DbgData(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    WE3 = 1'b1; A3 = a; WD3 = d;
    tick();
    WE3 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0) begin
      failures++;
      $display("FAIL reset_rd1 got %h/%h want 0", rd1_b, rd1_n);
    end
    checks++;
    if (rd2_b !== 32'h108 || rd2_n !== 32'h108) begin
      failures++;
      $display("FAIL reset_rd2_r15 got %h/%h want 108", rd2_b, rd2_n);
    end
    checks++;
    if (dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
      failures++;
      $display("FAIL reset_dbg got %h/%h want 0", dbg_b, dbg_n);
    end
    #1 rst_n = 1'b1;
    tick();
    wr(4'd2, 32'h1234_5678);
    A1 = 4'd2; A2 = 4'd2; DbgAddr = 4'd2;
    tick();
    checks++;
    if (rd1_b !== 32'h1234_5678 || dbg_n !== 32'h1234_5678) begin
      failures++;
      $display("FAIL pre_reset_val got %h/%h want 12345678", rd1_b, dbg_n);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd2_n !== 32'h0 ||
        dbg_b !== 32'h0 || dbg_n !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got %h %h %h %h want 0",
               rd1_b, rd2_n, dbg_b, dbg_n);
    end
    // write attempted while reset held must be lost
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'hFFFF_FFFF;
    tick();
    WE3 = 1'b0;
    checks++;
    if (rd1_n !== 32'h0) begin
      failures++;
      $display("FAIL reset_over_write got %h want 0", rd1_n);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read;
    wr(4'd3, 32'hDEAD_BEEF);
    A1 = 4'd3; A2 = 4'd4;
    #1;
    checks++;
    if (rd1_b !== 32'hDEAD_BEEF || rd1_n !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_rd1 got %h/%h want deadbeef", rd1_b, rd1_n);
    end
    checks++;
    if (rd2_b !== 32'h0 || rd2_n !== 32'h0) begin
      failures++;
      $display("FAIL wr_rd2 got %h/%h want 0", rd2_b, rd2_n);
    end
  endtask

  task automatic test_r15;
    int bad;
    A1 = 4'd15; A2 = 4'd15;
    #1;
    checks++;
    if (rd1_b !== 32'h108 || rd2_b !== 32'h108 ||
        rd1_n !== 32'h108 || rd2_n !== 32'h108) begin
      failures++;
      $display("FAIL r15_read got %h %h want 108", rd1_b, rd2_n);
    end
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h55;
    #1;
    checks++;
    if (rd1_b !== 32'h108) begin
      failures++;
      $display("FAIL r15_no_fwd got %h want 108", rd1_b);
    end
    tick();
    WE3 = 1'b0;
    checks++;
    if (rd1_b !== 32'h108 || rd1_n !== 32'h108) begin
      failures++;
      $display("FAIL r15_after_wr got %h/%h want 108", rd1_b, rd1_n);
    end
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      A1 = 4'(k);
      #1;
      if (rd1_n !== ((k == 3) ? 32'hDEAD_BEEF : 32'h0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL r15_wr_side_effect got %0d bad regs want 0", bad);
    end
  endtask

  task automatic test_bypass;
    wr(4'd5, 32'h11);
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'h22; A1 = 4'd5; A2 = 4'd5;
    #1;
    checks++;
    if (rd1_b !== 32'h22 || rd2_b !== 32'h22) begin
      failures++;
      $display("FAIL bypass_on got %h/%h want 22", rd1_b, rd2_b);
    end
    checks++;
    if (rd1_n !== 32'h11 || rd2_n !== 32'h11) begin
      failures++;
      $display("FAIL bypass_off_pre got %h/%h want 11", rd1_n, rd2_n);
    end
    tick();
    WE3 = 1'b0;
    checks++;
    if (rd1_n !== 32'h22 || rd1_b !== 32'h22) begin
      failures++;
      $display("FAIL bypass_off_post got %h/%h want 22", rd1_n, rd1_b);
    end
    WE3 = 1'b1; A3 = 4'd6; WD3 = 32'h99; A1 = 4'd5; A2 = 4'd6;
    #1;
    checks++;
    if (rd1_b !== 32'h22 || rd2_b !== 32'h99) begin
      failures++;
      $display("FAIL bypass_addr_match got %h/%h want 22/99", rd1_b, rd2_b);
    end
    tick();
    WE3 = 1'b0;
  endtask

  task automatic test_debug;
    DbgAddr = 4'd0;
    wr(4'd7, 32'hA5A5_A5A5);
    DbgAddr = 4'd7;
    #1;
    checks++;
    if (dbg_b !== 32'h0) begin
      failures++;
      $display("FAIL dbg_pre_edge got %h want 0", dbg_b);
    end
    tick();
    checks++;
    if (dbg_b !== 32'hA5A5_A5A5 || dbg_n !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL dbg_latency got %h/%h want a5a5a5a5", dbg_b, dbg_n);
    end
    wr(4'd7, 32'h1);
    checks++;
    if (dbg_b !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL dbg_no_bypass got %h want a5a5a5a5", dbg_b);
    end
    tick();
    checks++;
    if (dbg_b !== 32'h1 || dbg_n !== 32'h1) begin
      failures++;
      $display("FAIL dbg_edge_n1 got %h/%h want 1", dbg_b, dbg_n);
    end
    DbgAddr = 4'd15;
    tick();
    checks++;
    if (dbg_b !== 32'h108) begin
      failures++;
      $display("FAIL dbg_r15 got %h want 108", dbg_b);
    end
  endtask

  task automatic test_sweep;
    logic [31:0] e1, e2;
    for (int k = 0; k < 15; k++) wr(4'(k), 32'(k) * 32'h0101_0101);
    for (int k = 0; k < 15; k++) begin
      A1 = 4'(k); A2 = 4'(14 - k); DbgAddr = 4'(k);
      e1 = 32'(k) * 32'h0101_0101;
      e2 = 32'(14 - k) * 32'h0101_0101;
      tick();
      checks++;
      if (rd1_b !== e1 || rd1_n !== e1 ||
          rd2_b !== e2 || rd2_n !== e2) begin
        failures++;
        $display("FAIL sweep_rd r%0d got %h %h want %h %h",
                 k, rd1_b, rd2_n, e1, e2);
      end
      checks++;
      if (dbg_b !== e1 || dbg_n !== e1) begin
        failures++;
        $display("FAIL sweep_dbg r%0d got %h/%h want %h",
                 k, dbg_b, dbg_n, e1);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; WE3 = 1'b0; A3 = '0; WD3 = '0;
    A1 = 4'd0; A2 = 4'd15; R15 = 32'h108; DbgAddr = '0;
    test_reset();
    test_write_read();
    test_r15();
    test_bypass();
    test_debug();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
